bram_responder: RTL and testbench
=================================

Name: bram_responder

Overview:
- Synthesizable single-port BRAM responder: the memory side of the bram_en/bram_we/bram_addr/bram_wdata/bram_rdata port driven by our BRAM-master FSM blocks (e.g. adder datapaths).
- Gives simulation and FPGA builds a behavioural BRAM with programmable read latency, byte-lane writes and write-first semantics.
- Adds a read-valid sideband and a sticky out-of-range error flag.

Parameters:
- ADDR_WIDTH, 15, byte-address width of bram_addr.
- DEPTH, 1024, number of 32-bit words; legal range 1..2^(ADDR_WIDTH-2).
- RD_LATENCY, 2, clocks from the edge sampling a read to bram_rdata update; legal 1..4.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- bram_en  input  1  access enable; each cycle with en=1 is one access.
- bram_we  input  4  byte-lane write enables; bit i covers wdata[8i+7:8i].
- bram_addr  input  ADDR_WIDTH  byte address; word index = bram_addr[ADDR_WIDTH-1:2]; bits [1:0] ignored.
- bram_wdata  input  32  write data.
- bram_rdata  output  32  read data; holds its value between updates.
- rd_valid  output  1  one-cycle pulse coincident with each bram_rdata update.
- addr_err  output  1  sticky out-of-range flag.
- clear_err  input  1  clears addr_err.

Behaviour:
- Reset: clock clk; reset resetn, synchronous, active-low. On reset, bram_rdata=0, rd_valid=0, addr_err=0, and all in-flight reads are flushed (no rd_valid is produced for them). Memory array is not reset; contents persist across reset and are undefined at power-up.
- Access: at each edge with en=1, the word index is sampled.
  - If we!=0 and the index is in range, the enabled byte lanes are written at that edge.
  - Every en=1 cycle is also a read, whether or not we is set.
- Write-first: the read data is the post-write merged word, not the old contents.
- Read pipeline: RD_LATENCY-stage shift register of {valid, data}. Data sampled at edge N appears on bram_rdata with rd_valid=1 after edge N+RD_LATENCY-1.
  - RD_LATENCY=1: data is visible in the cycle right after the sampling edge.
  - RD_LATENCY=2: the master waits one extra cycle.
- Throughput: one access per cycle. Back-to-back accesses return in issue order, one per cycle, with no bubbles.
- en=0: no read and no write; bram_we and bram_wdata are ignored; bram_rdata holds; rd_valid=0 once the pipeline drains.
- Out-of-range: index >= DEPTH.
  - Write is dropped.
  - Read returns 32'h0 with the normal latency and rd_valid.
  - addr_err is set at the sampling edge.
- addr_err: clear_err=1 clears it at the next edge. If a new error and clear_err occur in the same cycle, set wins.
- Reset mid-operation: a write at the same edge as resetn=0 is dropped. Reads issued before reset never produce rd_valid.
- Widths: bram_rdata/bram_wdata fixed at 32 bits; partial writes modify only the enabled lanes.

Optional Feature:
- Macro: BRAM_RESP_CNT_EN.
- Defined: adds outputs rd_count[15:0] and wr_count[15:0].
  - wr_count increments on each accepted in-range write (en=1, we!=0).
  - rd_count increments on each rd_valid pulse.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined: ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Basic read (RD_LATENCY=2): write 0x00000005 @0x0 and 0x00000007 @0x4 with we=F; read @0x0 at edge N -> bram_rdata=0x00000005 with rd_valid=1 after edge N+1; read @0x4 -> 0x00000007.
- Byte lanes: write 0x11223344 @0x8 with we=F, then write 0xAABBCCDD @0x8 with we=4'b0101, then read @0x8 -> 0x11BB33DD.
- Write-first: single cycle en=1, we=F, addr 0xC, wdata 0xDEADBEEF -> after latency bram_rdata=0xDEADBEEF, rd_valid=1.
- Streaming: reads @0x0, 0x4, 0x8 on consecutive cycles -> three consecutive rd_valid pulses returning 0x5, 0x7, 0x11BB33DD in order; RD_LATENCY=1 build shows the same sequence one cycle earlier.
- Out-of-range (DEPTH=1024): write 0xFFFFFFFF @0x1000 -> addr_err=1, word 0 unchanged; read @0x1000 -> 0x0 with rd_valid; clear_err=1 -> addr_err=0 next cycle; clear_err plus a new bad read in the same cycle -> addr_err stays 1.
- Reset mid-read: read @0x0 at edge N, resetn=0 at edge N+1 -> no rd_valid, bram_rdata=0; after release, read @0x4 -> 0x00000007 (memory retained). With BRAM_RESP_CNT_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/bram_responder_if.sv
// Bus between a BRAM-master FSM and the memory side. Same signal names
// as the existing bram_* port so that master blocks connect unchanged.
interface bram_responder_if #(
    parameter int ADDR_WIDTH = 15
) ();
    logic                  bram_en;
    logic [3:0]            bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [31:0]           bram_wdata;
    logic [31:0]           bram_rdata;
    logic                  rd_valid;

    modport master (
        output bram_en, bram_we, bram_addr, bram_wdata,
        input  bram_rdata, rd_valid
    );

    modport slave (
        input  bram_en, bram_we, bram_addr, bram_wdata,
        output bram_rdata, rd_valid
    );
endinterface

// File: rtl/bram_responder.sv
// Behavioural single-port BRAM: byte-lane writes, write-first reads, programmable
// read latency, read-valid pulse and sticky range error. Define BRAM_RESP_CNT_EN for access counters.
module bram_responder #(
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    bram_responder_if.slave         bus,
    output logic                    addr_err,
    input  logic                    clear_err
`ifdef BRAM_RESP_CNT_EN
    ,
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count
`endif
);
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_LIM = DEPTH[IDX_W:0];

    logic [31:0]       mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              in_range;
    logic              access;
    logic              do_write;
    logic [31:0]       merged;
    logic              unused_addr_lsbs;

    logic [RD_LATENCY-1:0] pipe_v;
    logic [31:0]           pipe_d [RD_LATENCY];

    assign idx              = bus.bram_addr[ADDR_WIDTH-1:2];
    assign mem_idx          = idx[MEM_AW-1:0];
    assign unused_addr_lsbs = ^bus.bram_addr[1:0];
    assign in_range         = {1'b0, idx} < DEPTH_LIM;
    assign access           = resetn && bus.bram_en;
    assign do_write         = access && in_range && (bus.bram_we != 4'b0000);

    // Write-first: the read returns the old word with the enabled lanes replaced.
    // Out-of-range accesses read as zero.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        merged = '0;
        if (in_range) begin
            for (int i = 0; i < 4; i++) begin
                merged[8*i +: 8] = bus.bram_we[i] ? bus.bram_wdata[8*i +: 8]
                                                  : mem[mem_idx][8*i +: 8];
            end
        end
    end

    // NOTE: the array has no reset; contents survive resetn and are undefined at power-up.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[mem_idx] <= merged;
        end
    end

    // Each data stage loads only behind a valid, so the last stage (bram_rdata)
    // holds between read returns.
    // NOTE: sequential state uses non-blocking assignments so stages shift, not ripple.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pipe_v   <= '0;
            addr_err <= 1'b0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe_d[k] <= '0;
            end
        end else begin
            pipe_v[0] <= access;
            if (access) begin
                pipe_d[0] <= merged;
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                if (pipe_v[k-1]) begin
                    pipe_d[k] <= pipe_d[k-1];
                end
            end
            // A new error in the same cycle as clear_err keeps the flag set.
            if (access && !in_range) begin
                addr_err <= 1'b1;
            end else if (clear_err) begin
                addr_err <= 1'b0;
            end
        end
    end

    assign bus.bram_rdata = pipe_d[RD_LATENCY-1];
    assign bus.rd_valid   = pipe_v[RD_LATENCY-1];

`ifdef BRAM_RESP_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (do_write && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
            if (bus.rd_valid && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_bram_responder.sv
// Scoreboard bench for bram_responder: a posedge reference model pushes expected
// read returns, a negedge monitor pops and compares them against the DUT.
module tb_bram_responder;
    localparam int AW    = 15;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    logic clear_err;
    logic addr_err;
`ifdef BRAM_RESP_CNT_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    bram_responder_if #(.ADDR_WIDTH(AW)) bus ();

    bram_responder #(
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .RD_LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .addr_err (addr_err),
        .clear_err(clear_err)
`ifdef BRAM_RESP_CNT_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          mon_on = 1'b0;
    exp_t        sb[$];
    logic [31:0] mem_m [int];
    logic        exp_err = 1'b0;
    logic [31:0] exp_hold = '0;
    int          wr_m = 0;
    int          pops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name, input int detail);
        n_checks++;
        n_errors++;
        $display("FAIL %s: cycle %0d, detail %0d", name, cyc, detail);
    endtask

    // Reference model: sees the bus as sampled at each rising edge.
    always @(posedge clk) begin
        int          idx;
        logic [31:0] mask;
        logic [31:0] word;
        exp_t        e;
        cyc++;
        mon_on = 1'b1;
        if (!resetn) begin
            sb.delete();
            exp_err  = 1'b0;
            exp_hold = '0;
            wr_m     = 0;
            pops     = 0;
        end else begin
            if (bus.bram_en) begin
                idx   = int'(bus.bram_addr[AW-1:2]);
                e.due = cyc + LAT - 1;
                if (idx < DEPTH) begin
                    mask = {{8{bus.bram_we[3]}}, {8{bus.bram_we[2]}},
                            {8{bus.bram_we[1]}}, {8{bus.bram_we[0]}}};
                    word = mem_m.exists(idx) ? mem_m[idx] : 32'hxxxxxxxx;
                    word = (word & ~mask) | (bus.bram_wdata & mask);
                    if (bus.bram_we != 4'b0000) begin
                        mem_m[idx] = word;
                        if (wr_m < 65535) wr_m++;
                    end
                    e.data = word;
                end else begin
                    e.data = 32'h0;
                end
                sb.push_back(e);
            end
            if (bus.bram_en && int'(bus.bram_addr[AW-1:2]) >= DEPTH) exp_err = 1'b1;
            else if (clear_err) exp_err = 1'b0;
        end
    end

    // Monitor: compares returns, latency, hold behaviour and the error flag.
    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (bus.rd_valid) begin
                if (sb.size() == 0) begin
                    report_fail("spurious rd_valid", 0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", bus.bram_rdata, e.data);
                    check("latency", cyc, e.due);
                    exp_hold = e.data;
                    pops++;
                end
            end else begin
                check("rdata hold", bus.bram_rdata, exp_hold);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    report_fail("missing rd_valid", e.due);
                end
            end
            check("addr_err", addr_err, exp_err);
        end
    end

    task automatic drive(input logic en, input logic [3:0] we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic clr);
        bus.bram_en    = en;
        bus.bram_we    = we;
        bus.bram_addr  = addr;
        bus.bram_wdata = wdata;
        clear_err      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, '0, 32'h0, 1'b0);
    endtask

    initial begin
        int          budget;
        logic [AW-1:0] a;
        resetn = 1'b0;
        clear_err = 1'b0;
        bus.bram_en = 1'b0;
        bus.bram_we = '0;
        bus.bram_addr = '0;
        bus.bram_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Basic writes and reads
        drive(1'b1, 4'hF, 15'h0000, 32'h00000005, 1'b0);
        drive(1'b1, 4'hF, 15'h0004, 32'h00000007, 1'b0);
        drive(1'b1, 4'h0, 15'h0000, 32'hFFFFFFFF, 1'b0);
        idle(2);
        drive(1'b1, 4'h0, 15'h0004, 32'h0, 1'b0);
        idle(2);
        // Byte lanes
        drive(1'b1, 4'hF, 15'h0008, 32'h11223344, 1'b0);
        drive(1'b1, 4'b0101, 15'h000A, 32'hAABBCCDD, 1'b0);
        drive(1'b1, 4'h0, 15'h0008, 32'h0, 1'b0);
        idle(2);
        // Write-first single cycle
        drive(1'b1, 4'hF, 15'h000C, 32'hDEADBEEF, 1'b0);
        idle(3);
        // Streaming reads
        drive(1'b1, 4'h0, 15'h0000, 32'h0, 1'b0);
        drive(1'b1, 4'h0, 15'h0004, 32'h0, 1'b0);
        drive(1'b1, 4'h0, 15'h0008, 32'h0, 1'b0);
        idle(3);
        // Out of range: dropped write, zero read, clear, set-wins
        drive(1'b1, 4'hF, 15'h1000, 32'hFFFFFFFF, 1'b0);
        drive(1'b1, 4'h0, 15'h0000, 32'h0, 1'b0);
        drive(1'b1, 4'h0, 15'h1000, 32'h0, 1'b0);
        idle(2);
        drive(1'b0, 4'h0, 15'h0, 32'h0, 1'b1);
        idle(1);
        drive(1'b1, 4'h0, 15'h1004, 32'h0, 1'b0);
        drive(1'b0, 4'h0, 15'h0, 32'h0, 1'b1);
        drive(1'b1, 4'h0, 15'h7FFC, 32'h0, 1'b1);
        idle(3);
        // Reset mid-read, plus a write at the reset edge that must be dropped
        drive(1'b1, 4'h0, 15'h0000, 32'h0, 1'b0);
        resetn = 1'b0;
        drive(1'b1, 4'hF, 15'h0004, 32'hBADBAD00, 1'b0);
        idle(1);
`ifdef BRAM_RESP_CNT_EN
        check("wr_count after reset", {16'h0, wr_count}, 32'h0);
        check("rd_count after reset", {16'h0, rd_count}, 32'h0);
`endif
        resetn = 1'b1;
        drive(1'b1, 4'h0, 15'h0004, 32'h0, 1'b0);
        idle(3);

        // Initialise a small working set, then random traffic
        for (int w = 0; w < 16; w++) drive(1'b1, 4'hF, AW'(w * 4), $urandom, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0)
                a = AW'(($urandom_range((1 << (AW - 2)) - 1, DEPTH) << 2) | $urandom_range(3));
            else
                a = AW'(($urandom_range(15) << 2) | $urandom_range(3));
            resetn = ($urandom_range(63) != 0);
            drive($urandom_range(3) != 0, ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom),
                  a, $urandom, $urandom_range(7) == 0);
        end
        resetn = 1'b1;

        budget = 0;
        while (sb.size() != 0 && budget < 20) begin
            idle(1);
            budget++;
        end
        idle(2);
        check("scoreboard drained", sb.size(), 0);
`ifdef BRAM_RESP_CNT_EN
        check("wr_count", {16'h0, wr_count}, wr_m);
        check("rd_count", {16'h0, rd_count}, pops);
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
